pc_sequencer: RTL and testbench

//   Multi-cycle control FSM for the reduced RISC-V core.

---
 rtl/pc_seq_pkg.sv | 38 +++
 rtl/seq_wait_timer.sv | 31 +++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// the registered control bundle and its Moore decode from state.
package pc_seq_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned TIMER_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    WB,
    HALT,
    FAULT
  } state_t;

  // Registered control outputs, all pure functions of the state being entered
  typedef struct packed {
    logic imem_req;
    logic pc_en;
    logic jmp_sel;
    logic busy;
    logic fault;
  } ctrl_t;

  // Moore decode; take is the branch decision that applies in WB
  function automatic ctrl_t decode_ctrl(state_t s, logic take);
    ctrl_t c;
    c          = '0;
    c.imem_req = (s == FETCH);
    c.pc_en    = (s == WB);
    c.jmp_sel  = (s == WB) & take;
    c.busy     = (s == FETCH) | (s == EXEC) | (s == WB);
    c.fault    = (s == FAULT);
    return c;
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait timer for instruction fetch.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to zero (held while not fetching)
//   en       : count up one per cycle, saturating at the terminal count
//   tc_c     : count has reached TIMEOUT-1 (combinational from the count)
module seq_wait_timer
  import pc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc_c
);

  logic [TIMER_W-1:0] count;

  assign tc_c = (count == TIMER_W'(TIMEOUT - 1));

  // Saturate at terminal count so a stalled enable can never wrap back to 0
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && !tc_c) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute/writeback controller for the reduced RISC-V core.
//   clk, rst     : clock, synchronous active-high reset (dominates all inputs)
//   start        : leave IDLE / resume from HALT
//   imem_ready   : instruction word valid this cycle
//   branch, eq   : branch decode and ALU zero flag, sampled in EXEC
//   halt_instr   : halt decode, sampled in EXEC
//   reg_wen_dec  : decoder writeback request, used in WB
//   imem_req     : fetch request at current PC
//   ir_load      : load IR (FETCH & imem_ready)
//   pc_en        : PC advances at next edge (once per retired instruction)
//   jmp_sel      : 1 selects PC+imm, 0 selects PC+4
//   reg_wen      : regfile write enable (WB & reg_wen_dec)
//   busy         : in FETCH/EXEC/WB
//   fault        : sticky fetch-timeout flag
//   instret      : retired-instruction count
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             imem_ready,
  input  logic             branch,
  input  logic             eq,
  input  logic             halt_instr,
  input  logic             reg_wen_dec,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             jmp_sel,
  output logic             reg_wen,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  state_t state;
  state_t nxt_c;
  ctrl_t  ctrl_q;
  logic   take_q;
  logic   take_d_c;
  logic   tc_c;

  seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state != FETCH),
    .en    (state == FETCH),
    .tc_c  (tc_c)
  );

  // Next-state selection; memory ready beats the timeout on the same cycle
  always_comb begin
    nxt_c = state;
    unique case (state)
      IDLE:    if (start) nxt_c = FETCH;
      FETCH: begin
        if (imem_ready)  nxt_c = EXEC;
        else if (tc_c)   nxt_c = FAULT;
      end
      EXEC:    nxt_c = halt_instr ? HALT : WB;
      WB:      nxt_c = FETCH;
      HALT:    if (start) nxt_c = FETCH;
      FAULT:   nxt_c = FAULT;
      default: nxt_c = IDLE;
    endcase
  end

  // Branch decision that will be visible in WB
  assign take_d_c = (state == EXEC) ? (branch & eq) : take_q;

  // State, registered Moore outputs, branch flop and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ctrl_q  <= '0;
      take_q  <= 1'b0;
      instret <= '0;
    end else begin
      state  <= nxt_c;
      ctrl_q <= decode_ctrl(nxt_c, take_d_c);
      if (state == EXEC) take_q <= branch & eq;
      if (state == WB)   instret <= instret + CNT_W'(1);
    end
  end

  assign imem_req = ctrl_q.imem_req;
  assign pc_en    = ctrl_q.pc_en;
  assign jmp_sel  = ctrl_q.jmp_sel;
  assign busy     = ctrl_q.busy;
  assign fault    = ctrl_q.fault;
  assign ir_load  = ctrl_q.imem_req & imem_ready;
  assign reg_wen  = ctrl_q.pc_en & reg_wen_dec;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural phase model of the sequencer.
module tb_pc_sequencer;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 32;

  typedef enum int {P_IDLE, P_FETCH, P_EXEC, P_WB, P_HALT, P_FAULT} phase_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             imem_ready;
  logic             branch;
  logic             eq;
  logic             halt_instr;
  logic             reg_wen_dec;
  logic             imem_req;
  logic             ir_load;
  logic             pc_en;
  logic             jmp_sel;
  logic             reg_wen;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] instret;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  phase_t           m_phase;
  int               m_wait;
  logic             m_take;
  logic [CNT_W-1:0] m_ret;

  pc_sequencer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_ready  (imem_ready),
    .branch      (branch),
    .eq          (eq),
    .halt_instr  (halt_instr),
    .reg_wen_dec (reg_wen_dec),
    .imem_req    (imem_req),
    .ir_load     (ir_load),
    .pc_en       (pc_en),
    .jmp_sel     (jmp_sel),
    .reg_wen     (reg_wen),
    .busy        (busy),
    .fault       (fault),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_wait  = 0;
    m_take  = 1'b0;
    m_ret   = '0;
  endtask

  // Compare every output with what the current phase and inputs require
  task automatic check_outputs();
    logic in_wb;
    in_wb = (m_phase == P_WB);
    chk("imem_req", 32'(imem_req), 32'(m_phase == P_FETCH));
    chk("ir_load",  32'(ir_load),  32'((m_phase == P_FETCH) && imem_ready));
    chk("pc_en",    32'(pc_en),    32'(in_wb));
    chk("jmp_sel",  32'(jmp_sel),  32'(in_wb && m_take));
    chk("reg_wen",  32'(reg_wen),  32'(in_wb && reg_wen_dec));
    chk("busy",     32'(busy),     32'(m_phase == P_FETCH || m_phase == P_EXEC || in_wb));
    chk("fault",    32'(fault),    32'(m_phase == P_FAULT));
    chk("instret",  32'(instret),  32'(m_ret));
  endtask

  // Advance the model one clock using the inputs present at the edge
  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    case (m_phase)
      P_IDLE:  if (start) begin m_phase = P_FETCH; m_wait = 0; end
      P_FETCH: begin
        if (imem_ready) m_phase = P_EXEC;
        else if (m_wait == int'(TIMEOUT) - 1) m_phase = P_FAULT;
        else m_wait++;
      end
      P_EXEC: begin
        m_take  = branch & eq;
        m_phase = halt_instr ? P_HALT : P_WB;
      end
      P_WB: begin
        m_ret   = m_ret + 1;
        m_phase = P_FETCH;
        m_wait  = 0;
      end
      P_HALT:  if (start) begin m_phase = P_FETCH; m_wait = 0; end
      default: m_phase = P_FAULT;
    endcase
  endtask

  // One clock: drive inputs, check outputs, clock, advance the model
  task automatic cycle(input logic r, input logic st, input logic rdy,
                       input logic br, input logic e, input logic hl, input logic rw);
    rst = r; start = st; imem_ready = rdy; branch = br; eq = e;
    halt_instr = hl; reg_wen_dec = rw;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ready = 1'b0; branch = 1'b0;
    eq = 1'b0; halt_instr = 1'b0; reg_wen_dec = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Reset state
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Straight-line code, zero-wait memory: three retirements
    cycle(0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0, 0, i[0]);
    chk("instret_after_three", 32'(instret), 32'd3);

    // Taken branch
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 1, 0, 0);
    chk("taken_wb_pc_en", 32'(pc_en), 32'd1);
    chk("taken_wb_jmp_sel", 32'(jmp_sel), 32'd1);
    cycle(0, 0, 1, 0, 0, 0, 1);

    // Not-taken branch
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0, 0);
    chk("nottaken_wb_jmp_sel", 32'(jmp_sel), 32'd0);
    cycle(0, 0, 1, 0, 0, 0, 0);

    // Halt, idle in HALT, then resume
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 1, 1);
    chk("halt_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk("resume_fetch", 32'(imem_req), 32'd1);

    // Memory timeout: fifteen not-ready cycles, then start is ignored
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    chk("fault_set", 32'(fault), 32'd1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 0);
    chk("fault_sticky", 32'(fault), 32'd1);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("fault_cleared", 32'(fault), 32'd0);

    // Ready arrives on the last allowed wait cycle
    cycle(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("late_ready_no_fault", 32'(fault), 32'd0);
    chk("late_ready_busy", 32'(busy), 32'd1);

    // Reset in the middle of writeback
    cycle(0, 0, 1, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 0, 0, 1);
    chk("rst_wb_pc_en", 32'(pc_en), 32'd0);
    chk("rst_wb_instret", 32'(instret), 32'd0);

    // Counter wrap: preload all-ones while in EXEC, retire once
    cycle(0, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    force dut.instret = {CNT_W{1'b1}};
    #1;
    release dut.instret;
    m_ret = {CNT_W{1'b1}};
    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0, 0);
    chk("instret_wrap", 32'(instret), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0),
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
